// File: rtl/log_weight_quantizer_pipe_if.sv
// Beat-level handshake bundle between weight fetch, the log quantizer and the PE weight regs.
// The master side drives weights and downstream ready; the slave side is the quantizer.
interface log_weight_quantizer_pipe_if #(
    parameter int LANES    = 4,
    parameter int IDX_BITS = 3
);
    logic                            i_valid;
    logic                            i_ready;
    logic [32*LANES-1:0]             i_weight;
    logic                            o_valid;
    logic                            o_ready;
    logic [(IDX_BITS+1)*LANES-1:0]   o_index;

    modport master (output i_valid, i_weight, o_ready, input  i_ready, o_valid, o_index);
    modport slave  (input  i_valid, i_weight, o_ready, output i_ready, o_valid, o_index);
endinterface

// File: rtl/log_weight_quantizer_pipe.sv
// Multi-lane fp32 -> {sign, log2 index} quantizer, two stages sharing one stall enable,
// with saturating counters of lanes clamped high and nonzero lanes clamped to zero.
module log_weight_quantizer_pipe #(
    parameter int LANES    = 4,
    parameter int IDX_BITS = 3,
    parameter int CNT_BITS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    log_weight_quantizer_pipe_if.slave   bus,
    input  logic [7:0]                   cfg_emin,
    input  logic                         cfg_round,
    input  logic                         i_cnt_clr,
    output logic [CNT_BITS-1:0]          o_sat_hi_cnt,
    output logic [CNT_BITS-1:0]          o_sat_lo_cnt
);
    localparam int L  = 2**IDX_BITS;
    localparam int CW = $clog2(LANES+1);
    localparam logic signed [9:0] D_HI = 10'(L-2);

    logic                               w_en;
    logic                               w_hs;
    logic [2:1]                         r_vld_pipe;

    logic [LANES-1:0]                   w_sign, w_zero, w_inf;
    logic [LANES-1:0][9:0]              w_d;
    logic [LANES-1:0]                   r_s1_sign, r_s1_zero, r_s1_inf;
    logic [LANES-1:0][9:0]              r_s1_d;

    logic [LANES-1:0][IDX_BITS-1:0]     w_idx;
    logic [LANES-1:0]                   w_hi, w_lo;
    logic [LANES-1:0][IDX_BITS:0]       r_index;
    logic [LANES-1:0]                   r_hi, r_lo;

    logic [CW-1:0]                      w_nhi, w_nlo;
    logic [CNT_BITS:0]                  w_hi_sum, w_lo_sum;
    logic [CNT_BITS-1:0]                r_hi_cnt, r_lo_cnt;

    // A full output stage that is not being drained freezes the whole pipe.
    assign w_en        = !r_vld_pipe[2] || bus.o_ready;
    assign w_hs        = r_vld_pipe[2] && bus.o_ready;
    assign bus.i_ready = w_en;
    assign bus.o_valid = r_vld_pipe[2];
    assign bus.o_index = r_index;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [7:0]          w_e;
        logic [8:0]          w_eeff;
        logic signed [9:0]   w_ds;
        logic [IDX_BITS-1:0] w_idx_l;
        logic                w_hi_l, w_lo_l;
        logic                w_unused_mant;

        assign w_e           = bus.i_weight[32*k+23 +: 8];
        assign w_eeff        = {1'b0, w_e} + {8'd0, cfg_round & bus.i_weight[32*k+22]};
        assign w_sign[k]     = bus.i_weight[32*k+31];
        assign w_zero[k]     = (w_e == 8'd0);
        assign w_inf[k]      = (w_e == 8'hFF);
        assign w_d[k]        = {1'b0, w_eeff} - {2'b00, cfg_emin};
        assign w_unused_mant = ^bus.i_weight[32*k +: 22];

        assign w_ds = r_s1_d[k];
        always_comb begin
            w_idx_l = '0;
            w_hi_l  = 1'b0;
            w_lo_l  = 1'b0;
            if (r_s1_zero[k]) begin
                w_idx_l = '0;
            end else if (r_s1_inf[k]) begin
                w_idx_l = IDX_BITS'(L-1);
                w_hi_l  = 1'b1;
            end else if (w_ds < 10'sd0) begin
                w_lo_l  = 1'b1;
            end else if (w_ds >= D_HI) begin
                w_idx_l = IDX_BITS'(L-1);
                w_hi_l  = 1'b1;
            end else begin
                w_idx_l = IDX_BITS'(r_s1_d[k] + 10'd1);
            end
        end
        assign w_idx[k] = w_idx_l;
        assign w_hi[k]  = w_hi_l;
        assign w_lo[k]  = w_lo_l;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_pipe <= '0;
            r_s1_sign  <= '0;
            r_s1_zero  <= '0;
            r_s1_inf   <= '0;
            r_s1_d     <= '0;
            r_index    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else if (w_en) begin
            r_vld_pipe <= {r_vld_pipe[1], bus.i_valid};
            r_s1_sign  <= w_sign;
            r_s1_zero  <= w_zero;
            r_s1_inf   <= w_inf;
            r_s1_d     <= w_d;
            for (int k = 0; k < LANES; k++) r_index[k] <= {r_s1_sign[k], w_idx[k]};
            r_hi       <= w_hi;
            r_lo       <= w_lo;
        end
    end

    always_comb begin
        w_nhi = '0;
        w_nlo = '0;
        for (int k = 0; k < LANES; k++) begin
            w_nhi = w_nhi + CW'(r_hi[k]);
            w_nlo = w_nlo + CW'(r_lo[k]);
        end
    end

    // One extra sum bit detects overflow so the counters stick at all-ones.
    assign w_hi_sum = {1'b0, r_hi_cnt} + (CNT_BITS+1)'(w_nhi);
    assign w_lo_sum = {1'b0, r_lo_cnt} + (CNT_BITS+1)'(w_nlo);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi_cnt <= '0;
            r_lo_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_hi_cnt <= '0;
            r_lo_cnt <= '0;
        end else if (w_hs) begin
            r_hi_cnt <= w_hi_sum[CNT_BITS] ? '1 : w_hi_sum[CNT_BITS-1:0];
            r_lo_cnt <= w_lo_sum[CNT_BITS] ? '1 : w_lo_sum[CNT_BITS-1:0];
        end
    end

    assign o_sat_hi_cnt = r_hi_cnt;
    assign o_sat_lo_cnt = r_lo_cnt;
endmodule

// File: tb/tb_log_weight_quantizer_pipe.sv
// Random and directed stimulus for the log weight quantizer, checked against a
// per-lane arithmetic model and a queue of expected beats.
module tb_log_weight_quantizer_pipe;
    localparam int LANES = 4;
    localparam int IB    = 3;
    localparam int L     = 2**IB;
    localparam int CMAX  = 65535;

    typedef struct {
        logic [15:0] idx;
        int          nh;
        int          nl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg_emin;
    logic        cfg_round;
    logic        i_cnt_clr;
    logic [15:0] o_sat_hi_cnt, o_sat_lo_cnt;

    log_weight_quantizer_pipe_if #(.LANES(LANES), .IDX_BITS(IB)) bus ();

    log_weight_quantizer_pipe #(.LANES(LANES), .IDX_BITS(IB), .CNT_BITS(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .cfg_emin     (cfg_emin),
        .cfg_round    (cfg_round),
        .i_cnt_clr    (i_cnt_clr),
        .o_sat_hi_cnt (o_sat_hi_cnt),
        .o_sat_lo_cnt (o_sat_lo_cnt)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    int   n_out = 0;
    exp_t q[$];
    int   m_hi = 0, m_lo = 0;
    bit   hold = 0;
    logic [15:0] prev_idx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: derive the index straight from the exponent arithmetic.
    function automatic exp_t model(input logic [127:0] w, input int emin, input bit rnd);
        exp_t r;
        r.idx = '0; r.nh = 0; r.nl = 0;
        for (int k = 0; k < LANES; k++) begin
            int e, d, idx;
            e = int'(w[32*k+23 +: 8]);
            idx = 0;
            if (e == 0) idx = 0;
            else if (e == 255) begin idx = L-1; r.nh++; end
            else begin
                d = e + ((rnd && w[32*k+22]) ? 1 : 0) - emin;
                if (d < 0) begin idx = 0; r.nl++; end
                else if (d >= L-2) begin idx = L-1; r.nh++; end
                else idx = d + 1;
            end
            r.idx[4*k +: 4] = {w[32*k+31], 3'(idx)};
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            m_hi = 0; m_lo = 0; hold = 0;
        end else begin
            chk("sat_hi_cnt", o_sat_hi_cnt, 64'(m_hi));
            chk("sat_lo_cnt", o_sat_lo_cnt, 64'(m_lo));
            chk("i_ready", bus.i_ready, !bus.o_valid || bus.o_ready);
            if (hold) begin
                chk("hold_valid", bus.o_valid, 1);
                chk("hold_index", bus.o_index, prev_idx);
            end
            if (bus.o_valid && bus.o_ready) begin
                n_out++;
                if (q.size() == 0) chk("unexpected_output", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("o_index", bus.o_index, e.idx);
                    m_hi = (m_hi + e.nh > CMAX) ? CMAX : m_hi + e.nh;
                    m_lo = (m_lo + e.nl > CMAX) ? CMAX : m_lo + e.nl;
                end
            end
            if (i_cnt_clr) begin m_hi = 0; m_lo = 0; end
            if (bus.i_valid && bus.i_ready)
                q.push_back(model(bus.i_weight, int'(cfg_emin), cfg_round));
            hold     = bus.o_valid && !bus.o_ready;
            prev_idx = bus.o_index;
        end
    end

    task automatic send_beat(input logic [127:0] w, input logic [7:0] emin, input bit rnd);
        bit acc;
        int cnt;
        bus.i_valid = 1; bus.i_weight = w; cfg_emin = emin; cfg_round = rnd;
        cnt = 0;
        do begin
            @(negedge clk); acc = bus.i_ready;
            @(posedge clk); #1; cnt++;
        end while (!acc && cnt < 50);
        if (!acc) chk("send_timeout", 0, 1);
        bus.i_valid = 0;
    endtask

    // Beat accepted at edge 1 must be presented after edge 2 and drained at edge 3.
    task automatic directed(input string name, input logic [127:0] w, input logic [7:0] emin,
                            input bit rnd, input logic [15:0] exp);
        bus.o_ready = 1;
        send_beat(w, emin, rnd);
        @(posedge clk); #1;
        chk({name, "_valid"}, bus.o_valid, 1);
        chk(name, bus.o_index, exp);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_w(input int emin);
        int kind, e;
        kind = $urandom_range(0, 9);
        if (kind == 0) return {1'($urandom), 31'($urandom_range(0, 8388607))};
        if (kind == 1) return {1'($urandom), 8'hFF, 23'($urandom)};
        e = emin + $urandom_range(0, L+5) - 4;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        return {1'($urandom), 8'(e), 23'($urandom)};
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] w;
        int n0, sent;
        bit acc;
        rst = 0; bus.i_valid = 0; bus.i_weight = '0; bus.o_ready = 1;
        cfg_emin = 8'd124; cfg_round = 0; i_cnt_clr = 0;
        #3;
        chk("rst_o_valid", bus.o_valid, 0);
        chk("rst_o_index", bus.o_index, 0);
        chk("rst_hi", o_sat_hi_cnt, 0);
        chk("rst_lo", o_sat_lo_cnt, 0);
        @(posedge clk); #1; rst = 1;
        @(posedge clk); #1;
        chk("rst_i_ready", bus.i_ready, 1);

        directed("t1_basic", {32'h0, 32'h0, 32'hBE000000, 32'h3F800000}, 8'd124, 0, 16'h0094);
        directed("t2_trunc", {32'h0, 32'h0, 32'h0, 32'h3FC00000}, 8'd124, 0, 16'h0004);
        directed("t2_round", {32'h0, 32'h0, 32'h40FFFFFF, 32'h3FC00000}, 8'd124, 1, 16'h0075);
        chk("t2_hi", o_sat_hi_cnt, 1);
        directed("t3_special", {32'hFF800000, 32'h7F800000, 32'h3D000000, 32'h0}, 8'd124, 0, 16'hF700);
        chk("t3_hi", o_sat_hi_cnt, 3);
        chk("t3_lo", o_sat_lo_cnt, 1);
        directed("t4_emin120", {96'h0, 32'h3D800000}, 8'd120, 0, 16'h0004);
        directed("t4_emin0", {96'h0, 32'h00800000}, 8'd0, 0, 16'h0002);

        // Stall mid-stream for three cycles.
        n0 = n_out; sent = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            bus.i_valid  = (sent < 8);
            bus.i_weight = {1'(sent >> 2), 31'h3E000000, 1'(sent >> 1), 31'h3E000000,
                            1'(sent), 31'h3E000000, 1'b0, 8'(124 + sent % 6), 23'h0};
            cfg_emin = 8'd124; cfg_round = 0;
            bus.o_ready = !(c >= 4 && c < 7);
            @(negedge clk); acc = bus.i_valid && bus.i_ready;
            if (acc) sent++;
        end
        @(posedge clk); #1; bus.i_valid = 0; bus.o_ready = 1;
        repeat (4) @(posedge clk); #1;
        chk("t5_out_count", n_out - n0, 8);
        chk("t5_queue_empty", q.size(), 0);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            int em;
            @(posedge clk); #1;
            em = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : 124;
            cfg_emin = 8'(em); cfg_round = 1'($urandom);
            for (int k = 0; k < LANES; k++) w[32*k +: 32] = rand_w(em);
            bus.i_weight = w;
            bus.i_valid  = ($urandom_range(0, 3) != 0);
            bus.o_ready  = ($urandom_range(0, 9) < 7);
            i_cnt_clr    = ($urandom_range(0, 49) == 0);
        end
        @(posedge clk); #1; bus.i_valid = 0; bus.o_ready = 1; i_cnt_clr = 0;
        repeat (5) @(posedge clk); #1;
        chk("rand_drain", q.size(), 0);

        // Drive the high counter to its ceiling.
        i_cnt_clr = 1; @(posedge clk); #1; i_cnt_clr = 0;
        cfg_emin = 8'd124; cfg_round = 0;
        bus.i_valid = 1; bus.i_weight = {4{32'h7F800000}};
        repeat (16383) @(posedge clk);
        #1; bus.i_weight = {64'h0, {2{32'h7F800000}}};
        @(posedge clk); #1; bus.i_valid = 0;
        repeat (3) @(posedge clk); #1;
        chk("t6_preload", o_sat_hi_cnt, 16'hFFFE);
        directed("t6_inf", {4{32'h7F800000}}, 8'd124, 0, 16'h7777);
        chk("t6_sat", o_sat_hi_cnt, 16'hFFFF);
        directed("t6_inf2", {4{32'h7F800000}}, 8'd124, 0, 16'h7777);
        chk("t6_no_wrap", o_sat_hi_cnt, 16'hFFFF);

        send_beat({4{32'h7F800000}}, 8'd124, 0);
        @(posedge clk); #1;
        chk("t6_clr_valid", bus.o_valid, 1);
        i_cnt_clr = 1;
        @(posedge clk); #1; i_cnt_clr = 0;
        chk("t6_clr_hi", o_sat_hi_cnt, 0);

        // Reset with two beats in flight.
        bus.o_ready = 0;
        send_beat({4{32'h7F800000}}, 8'd124, 0);
        send_beat({4{32'h3F800000}}, 8'd124, 0);
        chk("t6_inflight", bus.o_valid, 1);
        rst = 0; #1;
        chk("t6_rst_valid", bus.o_valid, 0);
        chk("t6_rst_index", bus.o_index, 0);
        @(posedge clk); #1; rst = 1; bus.o_ready = 1;
        chk("t6_rst_ready", bus.i_ready, 1);
        repeat (5) @(posedge clk); #1;
        chk("t6_no_output", bus.o_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
